disp_vramctrl: RTL and testbench

DISP_VRAMCTRL -- requirements
Module: disp_vramctrl

---
 rtl/disp_vramctrl.sv | 83 ++++++++
 tb/tb_disp_vramctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_vramctrl.sv
// disp_vramctrl: fetches one display frame from VRAM as AXI read bursts and streams the beats into a pixel FIFO
module disp_vramctrl #(
    parameter int H_PIX  = 640,
    parameter int V_LINE = 480,
    parameter int BURST  = 16
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        DISPON,
    input  logic        VRSTART,
    input  logic [28:0] DISPADDR,
    input  logic        BUF_WREADY,
    output logic        FIFORST,
    output logic [63:0] FIFOIN,
    output logic        FIFOWR,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [63:0] RDATA,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic        BUSY
);
    localparam int BURSTS = H_PIX * V_LINE / 2 / BURST;
    localparam int CW = $clog2(BURSTS + 1);
    localparam logic [CW-1:0] LAST_BURST = CW'(BURSTS - 1);
    localparam logic [28:0] STEP = 29'(BURST * 8);

    typedef enum logic [1:0] {IDLE, WAITBUF, SETADDR, READ} state_t;

    state_t state, state_nx;
    logic [28:0] addr;
    logic [CW-1:0] cnt;
    logic start, beat, done;

    assign start = state == IDLE && VRSTART && DISPON;
    assign beat = state == READ && RVALID;
    assign done = beat && RLAST;

    // state register
    always_ff @(posedge ACLK or negedge ARST)
        if (!ARST) state <= IDLE;
        else state <= state_nx;

    // next state; DISPON is only honoured between bursts so a burst is never cut short
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? WAITBUF : IDLE;
            WAITBUF: state_nx = !DISPON ? IDLE : BUF_WREADY ? SETADDR : WAITBUF;
            SETADDR: state_nx = ARREADY ? READ : SETADDR;
            READ:    state_nx = !done ? READ : (cnt == LAST_BURST || !DISPON) ? IDLE : WAITBUF;
            default: state_nx = IDLE;
        endcase
    end

    // frame address, burst count and the one-cycle FIFO flush at frame start
    always_ff @(posedge ACLK or negedge ARST)
        if (!ARST) begin
            addr <= '0;
            cnt <= '0;
            FIFORST <= 1'b0;
        end else begin
            FIFORST <= start;
            if (start) begin
                addr <= DISPADDR;
                cnt <= '0;
            end else if (done) begin
                addr <= addr + STEP;
                cnt <= cnt + CW'(1);
            end
        end

    assign ARVALID = state == SETADDR;
    assign ARADDR = ARVALID ? {3'b000, addr} : '0;
    assign ARLEN = ARVALID ? 8'(BURST - 1) : '0;
    assign RREADY = state == READ;
    assign FIFOWR = beat;
    assign FIFOIN = beat ? RDATA : '0;
    assign BUSY = state != IDLE;
endmodule

// File: tb/tb_disp_vramctrl.sv
// tb_disp_vramctrl: directed checks of the VRAM fetch controller against a small AXI read slave
module tb_disp_vramctrl;
    logic        ACLK = 0;
    logic        ARST = 0;
    logic        DISPON = 0;
    logic        VRSTART = 0;
    logic [28:0] DISPADDR = '0;
    logic        BUF_WREADY = 0;
    logic        FIFORST;
    logic [63:0] FIFOIN;
    logic        FIFOWR;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        BUSY;

    int vectors = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [31:0] ar_addrs[$];

    int ar_wait = 0;
    bit r_gap = 0;
    bit stray = 0;

    // 32x16 pixels -> 256 beats -> 16 bursts of 16 per frame
    disp_vramctrl #(.H_PIX(32), .V_LINE(16), .BURST(16)) dut (
        .ACLK(ACLK), .ARST(ARST), .DISPON(DISPON), .VRSTART(VRSTART), .DISPADDR(DISPADDR),
        .BUF_WREADY(BUF_WREADY), .FIFORST(FIFORST), .FIFOIN(FIFOIN), .FIFOWR(FIFOWR),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .BUSY(BUSY)
    );

    always #5 ACLK = ~ACLK;

    // AXI read slave: optional ARREADY delay, optional alternate-cycle RVALID gaps, optional stray RVALID
    initial begin
        bit ar_hs, r_hs, tog;
        int beats_left, av_cnt, ar_len;
        logic [31:0] gbeat;
        ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = '0;
        beats_left = 0; av_cnt = 0; ar_len = 0; gbeat = 0; tog = 0;
        forever begin
            @(negedge ACLK);
            ar_hs = ARVALID && ARREADY;
            r_hs = RVALID && RREADY;
            ar_len = int'(ARLEN);
            @(posedge ACLK);
            #1;
            if (!ARST) begin
                beats_left = 0; av_cnt = 0;
                ARREADY = 0; RVALID = 0; RLAST = 0;
            end else begin
                if (ar_hs) beats_left = ar_len + 1;
                if (r_hs && beats_left > 0) begin beats_left--; gbeat++; end
                ARREADY = ARVALID && av_cnt >= ar_wait;
                av_cnt = ARVALID ? av_cnt + 1 : 0;
                tog = !tog;
                RVALID = (beats_left > 0 && (!r_gap || tog)) || (stray && beats_left == 0);
                RLAST = beats_left == 1;
                RDATA = {32'hDA7A0000 + gbeat, ~gbeat};
            end
        end
    end

    // bus monitor: data pass-through, write strobe, single outstanding read, address stability under stall
    initial begin
        bit prev_stall;
        logic [31:0] prev_addr;
        logic [7:0] prev_len;
        prev_stall = 0; prev_addr = '0; prev_len = '0;
        forever begin
            @(negedge ACLK);
            if (FIFOWR === 1'b1) begin
                wr_cnt++;
                vectors++;
                if (FIFOIN !== RDATA) begin errors++; $display("FAIL fifoin: got %h want %h", FIFOIN, RDATA); end
            end
            vectors++;
            if (FIFOWR !== (RVALID && RREADY)) begin
                errors++; $display("FAIL fifowr_vs_beat: got %b want %b", FIFOWR, RVALID && RREADY);
            end
            vectors++;
            if ((ARVALID && RREADY) !== 1'b0) begin errors++; $display("FAIL outstanding: arvalid=%b rready=%b", ARVALID, RREADY); end
            if (prev_stall && ARVALID) begin
                vectors++;
                if (ARADDR !== prev_addr || ARLEN !== prev_len) begin
                    errors++; $display("FAIL ar_stable: got %h/%0d want %h/%0d", ARADDR, ARLEN, prev_addr, prev_len);
                end
            end
            if (ARVALID && ARREADY) ar_addrs.push_back(ARADDR);
            prev_stall = ARVALID && !ARREADY;
            prev_addr = ARADDR;
            prev_len = ARLEN;
        end
    end

    task automatic clear();
        ar_addrs.delete();
        wr_cnt = 0;
        ar_wait = 0;
        r_gap = 0;
        stray = 0;
    endtask

    task automatic start_frame();
        @(posedge ACLK); #1 VRSTART = 1;
        @(posedge ACLK); #1 VRSTART = 0;
    endtask

    task automatic wait_wr(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge ACLK); #2;
            if (wr_cnt >= n) begin ok = 1; break; end
        end
    endtask

    task automatic wait_ar(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge ACLK); #2;
            if (ar_addrs.size() >= n) begin ok = 1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge ACLK); #2;
            if (BUSY === 1'b0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        vectors++;
        if ({ARVALID, RREADY, FIFOWR, FIFORST, BUSY} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {ARVALID, RREADY, FIFOWR, FIFORST, BUSY});
        end
        vectors++;
        if (ARADDR !== 32'h0 || ARLEN !== 8'h0 || FIFOIN !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h/%h/%h want zeros", ARADDR, ARLEN, FIFOIN);
        end
        @(posedge ACLK); #1 ARST = 1;
    endtask

    task automatic test_first_frame();
        bit ok;
        clear();
        DISPADDR = 29'h0100_0000; DISPON = 1; BUF_WREADY = 1;
        @(posedge ACLK); #1 VRSTART = 1;
        @(negedge ACLK);
        vectors++;
        if (BUSY !== 1'b0 || FIFORST !== 1'b0) begin errors++; $display("FAIL pre_start: busy=%b fiforst=%b want 0/0", BUSY, FIFORST); end
        @(posedge ACLK); #1 VRSTART = 0;
        @(negedge ACLK);
        vectors++;
        if (FIFORST !== 1'b1 || BUSY !== 1'b1 || ARVALID !== 1'b0) begin
            errors++; $display("FAIL fiforst_pulse: fiforst=%b busy=%b arvalid=%b want 1/1/0", FIFORST, BUSY, ARVALID);
        end
        @(negedge ACLK);
        vectors++;
        if (FIFORST !== 1'b0) begin errors++; $display("FAIL fiforst_len: got %b want 0", FIFORST); end
        vectors++;
        if (ARVALID !== 1'b1 || ARADDR !== 32'h0100_0000 || ARLEN !== 8'd15) begin
            errors++; $display("FAIL first_ar: got %b %h %0d want 1 01000000 15", ARVALID, ARADDR, ARLEN);
        end
        wait_ar(2, ok);
        vectors++;
        if (!ok || ar_addrs[1] !== 32'h0100_0080) begin errors++; $display("FAIL second_ar: got %h want 01000080", ar_addrs[1]); end
        wait_idle(ok);
        vectors++;
        if (!ok || BUSY !== 1'b0) begin errors++; $display("FAIL frame_idle: busy=%b want 0", BUSY); end
        vectors++;
        if (ar_addrs.size() != 16 || wr_cnt != 256) begin
            errors++; $display("FAIL frame_counts: bursts %0d beats %0d want 16 256", ar_addrs.size(), wr_cnt);
        end
        vectors++;
        if (ar_addrs[15] !== 32'h0100_0780) begin errors++; $display("FAIL last_ar: got %h want 01000780", ar_addrs[15]); end
    endtask

    task automatic test_wrap();
        bit ok;
        clear();
        DISPADDR = 29'h1FFF_FF80;
        start_frame();
        wait_idle(ok);
        vectors++;
        if (!ok || ar_addrs[0] !== 32'h1FFF_FF80 || ar_addrs[1] !== 32'h0 || ar_addrs[15] !== 32'h700) begin
            errors++; $display("FAIL wrap: got %h %h %h want 1fffff80 00000000 00000700", ar_addrs[0], ar_addrs[1], ar_addrs[15]);
        end
    endtask

    task automatic test_bufwait();
        bit ok;
        int bad;
        clear();
        DISPADDR = 29'h0010_0000; BUF_WREADY = 1;
        start_frame();
        wait_ar(1, ok);
        BUF_WREADY = 0;
        wait_wr(16, ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL bufwait_burst: beats %0d want 16", wr_cnt); end
        bad = 0;
        repeat (500) begin
            @(negedge ACLK);
            if (ARVALID !== 1'b0 || BUSY !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL bufwait_hold: %0d bad cycles want 0", bad); end
        @(posedge ACLK); #1 BUF_WREADY = 1;
        @(negedge ACLK);
        vectors++;
        if (ARVALID !== 1'b0) begin errors++; $display("FAIL bufwait_rise0: arvalid=%b want 0", ARVALID); end
        @(negedge ACLK);
        vectors++;
        if (ARVALID !== 1'b1 || ARADDR !== 32'h0010_0080) begin
            errors++; $display("FAIL bufwait_rise1: got %b %h want 1 00100080", ARVALID, ARADDR);
        end
        DISPON = 0;
        wait_idle(ok);
        vectors++;
        if (!ok || wr_cnt != 32 || ar_addrs.size() != 2) begin
            errors++; $display("FAIL bufwait_end: beats %0d bursts %0d want 32 2", wr_cnt, ar_addrs.size());
        end
        DISPON = 1;
    endtask

    task automatic test_slow_slave();
        bit ok;
        logic [31:0] a0;
        clear();
        ar_wait = 3; r_gap = 1;
        DISPADDR = 29'h0040_0000; BUF_WREADY = 1;
        start_frame();
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (ARVALID === 1'b1) begin ok = 1; break; end
        end
        a0 = ARADDR;
        vectors++;
        if (!ok || a0 !== 32'h0040_0000) begin errors++; $display("FAIL slow_ar: got %h want 00400000", a0); end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (ARVALID !== 1'b1 || ARREADY !== 1'b0 || ARADDR !== a0 || ARLEN !== 8'd15) begin
                errors++; $display("FAIL slow_stall%0d: got %b %b %h %0d want 1 0 %h 15", k, ARVALID, ARREADY, ARADDR, ARLEN, a0);
            end
            @(negedge ACLK);
        end
        wait_wr(16, ok);
        vectors++;
        if (!ok || ar_addrs.size() != 1) begin errors++; $display("FAIL slow_burst: beats %0d bursts %0d want 16 1", wr_cnt, ar_addrs.size()); end
        DISPON = 0;
        wait_idle(ok);
        vectors++;
        if (!ok || wr_cnt != 16) begin errors++; $display("FAIL slow_stop: beats %0d want 16", wr_cnt); end
        DISPON = 1;
    endtask

    task automatic test_dispon_drop();
        bit ok;
        clear();
        DISPADDR = 29'h0080_0000;
        start_frame();
        wait_wr(20, ok);
        DISPON = 0;
        wait_idle(ok);
        repeat (20) @(posedge ACLK);
        #2;
        vectors++;
        if (!ok || wr_cnt != 32 || ar_addrs.size() != 2 || BUSY !== 1'b0) begin
            errors++; $display("FAIL dispon_drop: beats %0d bursts %0d busy %b want 32 2 0", wr_cnt, ar_addrs.size(), BUSY);
        end
        DISPON = 1;
    endtask

    task automatic test_vrstart_ignored();
        bit ok;
        clear();
        DISPADDR = 29'h0010_0000;
        start_frame();
        wait_wr(40, ok);
        DISPADDR = 29'h0300_0000;
        start_frame();
        wait_idle(ok);
        vectors++;
        if (!ok || ar_addrs.size() != 16 || wr_cnt != 256 || ar_addrs[15] !== 32'h0010_0780) begin
            errors++; $display("FAIL vrstart_ignored: bursts %0d beats %0d last %h want 16 256 00100780", ar_addrs.size(), wr_cnt, ar_addrs[15]);
        end
    endtask

    task automatic test_waitbuf_dispon();
        clear();
        BUF_WREADY = 0;
        start_frame();
        stray = 1;
        @(negedge ACLK);
        @(negedge ACLK);
        vectors++;
        if (BUSY !== 1'b1 || RVALID !== 1'b1 || FIFOWR !== 1'b0) begin
            errors++; $display("FAIL stray_beat: busy=%b rvalid=%b fifowr=%b want 1 1 0", BUSY, RVALID, FIFOWR);
        end
        @(posedge ACLK); #1 DISPON = 0;
        @(negedge ACLK);
        @(negedge ACLK);
        vectors++;
        if (BUSY !== 1'b0 || wr_cnt != 0 || ar_addrs.size() != 0) begin
            errors++; $display("FAIL waitbuf_dispon: busy %b beats %0d bursts %0d want 0 0 0", BUSY, wr_cnt, ar_addrs.size());
        end
        stray = 0;
        DISPON = 1;
        BUF_WREADY = 1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int w;
        clear();
        DISPADDR = 29'h0040_0000;
        start_frame();
        wait_wr(7, ok);
        ARST = 0;
        #1;
        vectors++;
        if ({ARVALID, RREADY, FIFOWR, FIFORST, BUSY} !== 5'b0 || ARADDR !== 32'h0 || ARLEN !== 8'h0 || FIFOIN !== 64'h0) begin
            errors++; $display("FAIL reset_async: ctrl %b addr %h len %h in %h want zeros", {ARVALID, RREADY, FIFOWR, FIFORST, BUSY}, ARADDR, ARLEN, FIFOIN);
        end
        w = wr_cnt;
        repeat (5) @(posedge ACLK);
        #2;
        vectors++;
        if (wr_cnt != w || BUSY !== 1'b0) begin errors++; $display("FAIL reset_hold: beats %0d busy %b want %0d 0", wr_cnt, BUSY, w); end
        ARST = 1;
        clear();
        DISPADDR = 29'h0200_0000;
        start_frame();
        wait_idle(ok);
        vectors++;
        if (!ok || ar_addrs[0] !== 32'h0200_0000 || ar_addrs.size() != 16 || wr_cnt != 256) begin
            errors++; $display("FAIL reset_restart: first %h bursts %0d beats %0d want 02000000 16 256", ar_addrs[0], ar_addrs.size(), wr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_wrap();
        test_bufwait();
        test_slow_slave();
        test_dispon_drop();
        test_vrstart_ignored();
        test_waitbuf_dispon();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
